// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage: fetches one 16-bit word per
// instruction over a req/valid handshake and resolves INC/JMP/JE/JNE/HLT.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [15:0]     instr,
  output logic            instr_valid,
  input  logic [2:0]      pc_sel,
  input  logic [15:0]     jump_target,
  input  logic            cmp_write,
  input  logic            cmp_eq,
  output logic [PC_W-1:0] pc,
  output logic            eq_flag,
  output logic            halted
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [2:0] SEL_INC = 3'b000;
  localparam logic [2:0] SEL_JMP = 3'b001;
  localparam logic [2:0] SEL_JE  = 3'b010;
  localparam logic [2:0] SEL_JNE = 3'b011;
  localparam logic [2:0] SEL_HLT = 3'b100;

  logic [1:0]      state;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] next_pc;

  assign pc_inc = pc + PC_W'(1);
  assign target = jump_target[PC_W-1:0];

  // Conditional branches look at the flag as it stands during this EXEC,
  // so a CMP in the same instruction cannot steer its own branch.
  always_comb begin
    next_pc = pc_inc;
    case (pc_sel)
      SEL_INC: next_pc = pc_inc;
      SEL_JMP: next_pc = target;
      SEL_JE:  next_pc = eq_flag ? target : pc_inc;
      SEL_JNE: next_pc = eq_flag ? pc_inc : target;
      SEL_HLT: next_pc = pc;
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      eq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          pc <= next_pc;
          if (cmp_write) eq_flag <= cmp_eq;
          state <= (pc_sel == SEL_HLT) ? HALT : FETCH;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the registered state.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);
  assign imem_addr   = pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage sitting directly upstream of the decoder. Holds the PC and the equality flag, fetches one 16-bit instruction at a time from instruction memory over a req/valid handshake, and presents it to the decoder for exactly one execute cycle. It then consumes the decoder's `pc_sel`/`jump_target` and the ALU compare result to compute the next PC, or halts.

## Interface
- `PC_W`, 16, PC and instruction-memory address width; `jump_target` is truncated to its low `PC_W` bits.
- `RESET_PC`, 0, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `start`  in  1  leaves IDLE when sampled high.
- `imem_addr`  out  PC_W  fetch address; equals `pc`.
- `imem_req`  out  1  fetch request.
- `imem_rdata`  in  16  instruction word; sampled when `imem_req && imem_valid`.
- `imem_valid`  in  1  memory response; ignored when `imem_req`=0.
- `instr`  out  16  registered instruction presented to the decoder.
- `instr_valid`  out  1  high for the single EXEC cycle.
- `pc_sel`  in  3  from decoder: 000 INC, 001 JMP, 010 JE, 011 JNE, 100 HLT; 101–111 treated as INC.
- `jump_target`  in  16  from decoder.
- `cmp_write`  in  1  from decoder; the current instruction is CMP.
- `cmp_eq`  in  1  from ALU; the operands of the current CMP are equal.
- `pc`  out  PC_W  current PC.
- `eq_flag`  out  1  stored compare result.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: `imem_req`=0. `start`=1 -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, held stable. On the edge where `imem_valid`=1: `instr` <= `imem_rdata` and state -> EXEC. Otherwise remain in FETCH, with no timeout.
- EXEC: `instr_valid`=1 and `imem_req`=0. `pc_sel`, `cmp_write` and `cmp_eq` are sampled at the end of this cycle, and the next PC is chosen as follows:
  - INC: `pc+1`, mod 2^PC_W, so the PC wraps from all-ones to 0.
  - JMP: `jump_target[PC_W-1:0]`.
  - JE: the target if `eq_flag`=1, else `pc+1`.
  - JNE: the target if `eq_flag`=0, else `pc+1`.
  - HLT: PC unchanged and state -> HALT.
  - For all other `pc_sel` values, state -> FETCH.
- Flag update: if `cmp_write`=1 in EXEC, `eq_flag` <= `cmp_eq`; otherwise `eq_flag` holds.
- Flag timing: JE/JNE use the `eq_flag` value held during their own EXEC cycle, i.e. the value set by an earlier CMP.
- `instr` holds its last value outside EXEC; the decoder must qualify with `instr_valid`.
- HALT: `halted`=1 and `imem_req`=0. `start` is ignored. Exit is by reset only.

## Timing
- Reset values: state=IDLE, `pc`=RESET_PC, `imem_req`=0, `instr`=0, `instr_valid`=0, `eq_flag`=0, `halted`=0.
- Reset assertion clears state asynchronously, including mid-FETCH. The outstanding request is abandoned and a late `imem_valid` is ignored.
- Zero-wait memory (`imem_valid` in the first request cycle) gives 2 cycles per instruction. Each memory wait cycle adds 1.
- `start` to first `imem_req`: 1 cycle.
- The new PC is visible on `pc`/`imem_addr` in the cycle after EXEC, together with `imem_req`=1.
- `imem_addr` changes only while `imem_req`=0.
- `halted` rises in the cycle after the HLT EXEC cycle.
- All outputs are registered, or decoded from registered state only. There is no combinational path from `imem_valid`, `pc_sel` or `cmp_*` to any output.

## Test plan
- Reset, then `start`, then memory returning INC-class words at 0,1,2 with zero wait: addresses 0,1,2 requested.
  - `instr_valid` pulses every 2nd cycle.
  - `eq_flag`=0, `halted`=0.
- Memory with 3 wait cycles per fetch: `imem_addr` stable and `imem_req` high for 4 cycles per fetch; `instr_valid` 1 cycle per fetch.
- Sequence `pc_sel` JMP target 0x02A, then CMP with `cmp_eq`=1, then JE to 0x010:
  - fetches at 0x02A and 0x02B, then 0x010.
  - Repeat with `cmp_eq`=0: JE falls through to 0x02C, and JNE to 0x010 is taken.
- `RESET_PC`=0xFFFF with INC: the PC wraps to 0x0000.
  - `jump_target`=0x1234 with `PC_W`=8 loads 0x34.
- HLT at PC 5: `halted`=1, `pc` stays 5, and no further `imem_req` even with `start` pulsed.
  - Reset deasserted then `start`: fetch resumes at RESET_PC.
- Reset asserted mid-FETCH with `imem_valid` arriving 1 cycle later: all outputs at reset values immediately, and the late response is ignored.
